// File: rtl/avalon_mm_reg_bridge.sv
// avalon_mm_reg_bridge
//   Registered Avalon-MM bridge with one transaction outstanding at a time.
//   An upstream command is latched in IDLE and replayed downstream. Read data
//   is captured a fixed PASS_READ_LATENCY cycles after the downstream accepts
//   the read. Upstream then sees a single non-stalled cycle.
//   Every output is driven straight from a flop.
// Ports
//   CLK, RESET            : clock (rising edge), async active-high reset
//   AVL_*                 : upstream slave side (read/write/addr/data/be in,
//                           readdata/waitrequest out)
//   PASS_*                : downstream master side (read/write/addr/data/be
//                           out, readdata/waitrequest in)
module avalon_mm_reg_bridge #(
  parameter int ADDR_WIDTH        = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int PASS_READ_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic [ADDR_WIDTH-1:0]   AVL_ADDR,
  input  logic [DATA_WIDTH-1:0]   AVL_WRITEDATA,
  input  logic [DATA_WIDTH/8-1:0] AVL_BYTEENABLE,
  output logic [DATA_WIDTH-1:0]   AVL_READDATA,
  output logic                    AVL_WAITREQUEST,
  output logic                    PASS_READ,
  output logic                    PASS_WRITE,
  output logic [ADDR_WIDTH-1:0]   PASS_ADDR,
  output logic [DATA_WIDTH-1:0]   PASS_WRITEDATA,
  output logic [DATA_WIDTH/8-1:0] PASS_BYTEENABLE,
  input  logic [DATA_WIDTH-1:0]   PASS_READDATA,
  input  logic                    PASS_WAITREQUEST
);

  localparam int BW     = DATA_WIDTH / 8;
  localparam int LAT_M1 = (PASS_READ_LATENCY > 0) ? PASS_READ_LATENCY - 1 : 0;
  localparam logic [2:0] CNT_INIT = 3'(LAT_M1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RWAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pread_q, pread_d;
  logic                  pwrite_q, pwrite_d;
  logic                  wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // A simultaneous read+write is taken as a write.
        if (AVL_WRITE || AVL_READ) begin
          state_d = S_CMD;
          is_wr_d = AVL_WRITE;
          addr_d  = AVL_ADDR;
          wdata_d = AVL_WRITEDATA;
          be_d    = AVL_BYTEENABLE;
        end
      end
      S_CMD: begin
        if (!PASS_WAITREQUEST) begin
          if (is_wr_q) begin
            state_d = S_RESP;
          end else if (PASS_READ_LATENCY == 0) begin
            rdata_d = PASS_READDATA;
            state_d = S_RESP;
          end else begin
            state_d = S_RWAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_RWAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = PASS_READDATA;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so decode them from the state being entered.
    pread_d  = (state_d == S_CMD) && !is_wr_d;
    pwrite_d = (state_d == S_CMD) &&  is_wr_d;
    wait_d   = (state_d != S_RESP);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= 3'd0;
      rdata_q  <= '0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      wait_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      wait_q   <= wait_d;
    end
  end

  assign AVL_READDATA    = rdata_q;
  assign AVL_WAITREQUEST = wait_q;
  assign PASS_READ       = pread_q;
  assign PASS_WRITE      = pwrite_q;
  assign PASS_ADDR       = addr_q;
  assign PASS_WRITEDATA  = wdata_q;
  assign PASS_BYTEENABLE = be_q;

endmodule

// File: tb/tb_avalon_mm_reg_bridge.sv
// Bench for avalon_mm_reg_bridge: four instances with read latency 0/1/2/7.
// The bench plays the downstream slave (a byte-enabled memory) and predicts
// completion cycle, strobes, and read data from the transaction rules.
module tb_avalon_mm_reg_bridge;
  localparam int NI = 4;
  localparam int LATS [NI] = '{0, 1, 2, 7};

  logic clk, rst;
  logic [NI-1:0]       avl_read, avl_write, avl_wait, pass_read, pass_write, pass_wait;
  logic [NI-1:0][7:0]  avl_addr, pass_addr;
  logic [NI-1:0][31:0] avl_wdata, avl_rdata, pass_wdata, pass_rdata;
  logic [NI-1:0][3:0]  avl_be, pass_be;

  int n_tot, n_bad;
  logic [31:0] mem [256];
  logic [31:0] rd_prev [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    avalon_mm_reg_bridge #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .PASS_READ_LATENCY(LATS[g])
    ) u_dut (
      .CLK(clk), .RESET(rst),
      .AVL_READ(avl_read[g]), .AVL_WRITE(avl_write[g]), .AVL_ADDR(avl_addr[g]),
      .AVL_WRITEDATA(avl_wdata[g]), .AVL_BYTEENABLE(avl_be[g]),
      .AVL_READDATA(avl_rdata[g]), .AVL_WAITREQUEST(avl_wait[g]),
      .PASS_READ(pass_read[g]), .PASS_WRITE(pass_write[g]), .PASS_ADDR(pass_addr[g]),
      .PASS_WRITEDATA(pass_wdata[g]), .PASS_BYTEENABLE(pass_be[g]),
      .PASS_READDATA(pass_rdata[g]), .PASS_WAITREQUEST(pass_wait[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance k with `stall` downstream wait cycles.
  task automatic run_txn(input int k, input bit wr, input bit rd, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input int stall);
    bit          is_wr = wr;
    int          lat   = LATS[k];
    int          acc   = 1 + stall;
    int          exp_done = 2 + stall + (wr ? 0 : lat);
    logic [31:0] exp_rd = wr ? rd_prev[k] : mem[a];
    bit          done = 0;
    @(posedge clk); #1;
    avl_read[k] = rd; avl_write[k] = wr; avl_addr[k] = a;
    avl_wdata[k] = wd; avl_be[k] = be;
    pass_wait[k] = 1'($urandom); pass_rdata[k] = $urandom;
    @(negedge clk);
    chk("idle_wait", 32'(avl_wait[k]), 32'd1);
    chk("idle_strb", 32'({pass_read[k], pass_write[k]}), 32'd0);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      // upstream noise while stalled must be ignored
      avl_read[k] = 1'($urandom); avl_write[k] = 1'($urandom);
      avl_addr[k] = 8'($urandom); avl_wdata[k] = $urandom; avl_be[k] = 4'($urandom);
      pass_wait[k] = (c <= stall);
      pass_rdata[k] = (!is_wr && c == acc + lat) ? mem[a] : $urandom;
      @(negedge clk);
      chk("strb", 32'({pass_read[k], pass_write[k]}),
          (c <= acc) ? (is_wr ? 32'd1 : 32'd2) : 32'd0);
      if (c <= acc) begin
        chk("p_addr", 32'(pass_addr[k]), 32'(a));
        chk("p_wdata", pass_wdata[k], wd);
        chk("p_be", 32'(pass_be[k]), 32'(be));
      end
      if (!avl_wait[k]) begin
        done = 1;
        chk("latency", c, exp_done);
        chk("rdata", avl_rdata[k], exp_rd);
      end else begin
        chk("rhold", avl_rdata[k], rd_prev[k]);
      end
    end
    chk("timeout", 32'(done), 32'd1);
    avl_read[k] = 1'b0; avl_write[k] = 1'b0; pass_wait[k] = 1'b0;
    if (is_wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[a][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rd_prev[k] = mem[a];
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_1cyc", 32'(avl_wait[k]), 32'd1);
    chk("rdata_keep", avl_rdata[k], rd_prev[k]);
  endtask

  initial begin
    n_tot = 0; n_bad = 0;
    rst = 1'b1;
    avl_read = '0; avl_write = '0; avl_addr = '0; avl_wdata = '0; avl_be = '0;
    pass_wait = '0; pass_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < NI; k++) rd_prev[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_wait", 32'(avl_wait[k]), 32'd1);
      chk("rst_strb", 32'({pass_read[k], pass_write[k]}), 32'd0);
      chk("rst_out", {pass_addr[k], pass_be[k], 20'd0} | pass_wdata[k] | avl_rdata[k], 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // directed cases
    run_txn(1, 1, 0, 8'h12, 32'hA5A5_0001, 4'hF, 0);
    mem[8'h34] = 32'hCAFE_F00D;
    run_txn(2, 0, 1, 8'h34, 32'h0, 4'hF, 0);
    chk("cafe", avl_rdata[2], 32'hCAFE_F00D);
    run_txn(0, 1, 0, 8'h40, 32'h1234_5678, 4'hF, 3);
    run_txn(2, 1, 1, 8'h34, 32'hDEAD_BEEF, 4'h3, 0);
    chk("rw_keep", avl_rdata[2], 32'hCAFE_F00D);
    run_txn(2, 0, 1, 8'h34, 32'h0, 4'hF, 1);
    chk("merged", avl_rdata[2], 32'hCAFE_BEEF);

    // back-to-back reads with a byteenable sweep on every latency
    for (int k = 0; k < NI; k++) begin
      run_txn(k, 0, 1, 8'h01, 32'h0, 4'h1, 0);
      run_txn(k, 0, 1, 8'h02, 32'h0, 4'h3, 0);
      run_txn(k, 0, 1, 8'h03, 32'h0, 4'hC, 0);
    end

    // reset in the middle of a latency-7 read wait
    @(posedge clk); #1;
    avl_read[3] = 1'b1; avl_addr[3] = 8'h21; pass_wait[3] = 1'b0;
    @(posedge clk); #1 avl_read[3] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) rd_prev[k] = '0;
    chk("mid_rst_wait", 32'(avl_wait[3]), 32'd1);
    chk("mid_rst_strb", 32'({pass_read[3], pass_write[3]}), 32'd0);
    chk("mid_rst_addr", 32'(pass_addr[3]), 32'd0);
    chk("mid_rst_rdata", avl_rdata[3] | avl_rdata[1], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("no_replay", 32'({pass_read[3], avl_wait[3]}), 32'd1);
    run_txn(3, 0, 1, 8'h21, 32'h0, 4'hF, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int k = $urandom_range(0, NI - 1);
      bit wr = 1'($urandom);
      bit rd = wr ? 1'($urandom) : 1'b1;
      run_txn(k, wr, rd, 8'($urandom_range(0, 15)), $urandom, 4'($urandom),
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
